// File: rtl/timer_status.sv
// timer_status
// Status and interrupt block for the 8-bit timer. Samples the counter every
// cycle, detects overflow (all-ones -> zero while counting up) and underflow
// (zero -> all-ones while counting down), records events in sticky status
// flags with overrun tracking and drives masked level interrupts.
//
// Ports:
//   pclk      in   system clock, rising edge
//   preset_n  in   synchronous active-low reset
//   cnt       in   current counter value
//   updw      in   count direction (0 = up, 1 = down)
//   load      in   counter load strobe (cnt takes the reload value)
//   wr_en     in   register write strobe
//   addr      in   0 = TSR (write-1-to-clear), 1 = TIER
//   wdata     in   write data
//   rdata     out  read data for addr (combinational)
//   irq_ovf   out  overflow interrupt (level)
//   irq_udf   out  underflow interrupt (level)
//   irq       out  irq_ovf | irq_udf
module timer_status #(
  parameter int CNT_W = 8
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             updw,
  input  logic             load,
  input  logic             wr_en,
  input  logic             addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             irq_ovf,
  output logic             irq_udf,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_ONES  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZEROS = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             vld_q, vld_d;
  logic [3:0]       tsr_q, tsr_d;
  logic [1:0]       tier_q, tier_d;

  logic             ovf_evt;
  logic             udf_evt;
  logic [3:0]       tsr_clr;

  always_comb begin
    cnt_d   = cnt;
    load_d  = load;
    vld_d   = 1'b1;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    tsr_clr = 4'b0000;
    tsr_d   = tsr_q;
    tier_d  = tier_q;

    // A jump caused by a load, or the comparison against the reset value of
    // cnt_q, must never look like a wrap.
    if (vld_q && !load_q) begin
      ovf_evt = (cnt_q == CNT_ONES)  && (cnt == CNT_ZEROS) && !updw;
      udf_evt = (cnt_q == CNT_ZEROS) && (cnt == CNT_ONES)  &&  updw;
    end

    if (wr_en && !addr) begin
      tsr_clr = wdata[3:0];
    end

    // Clear first, then OR in events so a same-cycle event wins. Overrun is
    // judged against the flag value before this cycle's clear.
    tsr_d    = tsr_q & ~tsr_clr;
    tsr_d[0] = tsr_d[0] | ovf_evt;
    tsr_d[1] = tsr_d[1] | udf_evt;
    tsr_d[2] = tsr_d[2] | (ovf_evt & tsr_q[0]);
    tsr_d[3] = tsr_d[3] | (udf_evt & tsr_q[1]);

    if (wr_en && addr) begin
      tier_d = wdata[1:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      cnt_q  <= CNT_ZEROS;
      load_q <= 1'b0;
      vld_q  <= 1'b0;
      tsr_q  <= 4'b0000;
      tier_q <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      load_q <= load_d;
      vld_q  <= vld_d;
      tsr_q  <= tsr_d;
      tier_q <= tier_d;
    end
  end

  always_comb begin
    irq_ovf = tsr_q[0] & tier_q[0];
    irq_udf = tsr_q[1] & tier_q[1];
    irq     = irq_ovf | irq_udf;
    rdata   = addr ? {6'b0, tier_q} : {4'b0, tsr_q};
  end

endmodule
